// File: rtl/enc4to2_stream.sv
// ============================================================================
//  Module   : enc4to2_stream
//  Function : Streaming 4-to-2 encoder; emits the 2-bit code of every set bit
//             of an accepted request word, one code per output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc4to2_stream #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_in_valid,
  input  logic [3:0] i_in_bits,
  output logic       o_in_ready,
  output logic       o_out_valid,
  output logic [1:0] o_out_code,
  output logic       o_out_last,
  input  logic       i_out_ready,
  output logic       o_onehot,
  output logic       o_zero_pulse
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  localparam logic [3:0] c_bit0 = 4'b0001;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_pending;
  logic [3:0] w_pending_next;
  logic       r_onehot;
  logic       w_onehot_next;
  logic       r_zero_pulse;
  logic       w_zero_pulse_next;
  logic [1:0] w_sel;
  logic       w_last;
  logic       w_in_single;

  // Later loop iterations win, so the loop direction sets the scan priority.
  always_comb begin
    w_sel = 2'b00;
    if (LSB_FIRST) begin
      for (int k = 3; k >= 0; k--) begin
        if (r_pending[k]) w_sel = 2'(k);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (r_pending[k]) w_sel = 2'(k);
      end
    end
  end

  assign w_last      = (r_pending != 4'd0) && ((r_pending & (r_pending - 4'd1)) == 4'd0);
  assign w_in_single = (i_in_bits & (i_in_bits - 4'd1)) == 4'd0;

  always_comb begin
    w_state_next      = r_state;
    w_pending_next    = r_pending;
    w_onehot_next     = r_onehot;
    w_zero_pulse_next = 1'b0;
    o_in_ready        = 1'b0;
    o_out_valid       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          if (i_in_bits == 4'd0) begin
            w_zero_pulse_next = 1'b1;
          end else begin
            w_pending_next = i_in_bits;
            w_onehot_next  = w_in_single;
            w_state_next   = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_pending_next = r_pending & ~(c_bit0 << w_sel);
          if (w_last) w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pending    <= 4'd0;
      r_onehot     <= 1'b0;
      r_zero_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pending    <= w_pending_next;
      r_onehot     <= w_onehot_next;
      r_zero_pulse <= w_zero_pulse_next;
    end
  end

  // Code and last flag come straight from the pending register, never from i_in_*.
  assign o_out_code   = w_sel;
  assign o_out_last   = w_last;
  assign o_onehot     = r_onehot;
  assign o_zero_pulse = r_zero_pulse;

endmodule

`default_nettype wire

// File: tb/tb_enc4to2_stream.sv
// ============================================================================
//  Module   : tb_enc4to2_stream
//  Function : Self-checking bench for enc4to2_stream, both scan orders.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enc4to2_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_bits;
  logic       out_ready;

  logic       l_in_ready, l_out_valid, l_out_last, l_onehot, l_zero_pulse;
  logic [1:0] l_out_code;
  logic       m_in_ready, m_out_valid, m_out_last, m_onehot, m_zero_pulse;
  logic [1:0] m_out_code;

  enc4to2_stream #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .i_in_bits(in_bits), .o_in_ready(l_in_ready),
    .o_out_valid(l_out_valid), .o_out_code(l_out_code), .o_out_last(l_out_last),
    .i_out_ready(out_ready), .o_onehot(l_onehot), .o_zero_pulse(l_zero_pulse)
  );

  enc4to2_stream #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .i_in_bits(in_bits), .o_in_ready(m_in_ready),
    .o_out_valid(m_out_valid), .o_out_code(m_out_code), .o_out_last(m_out_last),
    .i_out_ready(out_ready), .o_onehot(m_onehot), .o_zero_pulse(m_zero_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each accepted word becomes a list of codes to be emitted.
  int   q_lsb[$];
  int   q_msb[$];
  logic ref_onehot;
  logic ref_zero;

  typedef struct {
    logic [3:0] bits;
    int         n;
    logic [7:0] lsb_seq;  // code j at [2j+1:2j]
    logic [7:0] msb_seq;
    logic       onehot;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_lsb.delete();
    q_msb.delete();
    ref_onehot = 1'b0;
    ref_zero   = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    ref_zero = 1'b0;
    if (q_lsb.size() == 0) begin
      if (in_valid) begin
        if (in_bits == 4'd0) begin
          ref_zero = 1'b1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (in_bits[k]) begin
              q_lsb.push_back(k);
              q_msb.push_front(k);
            end
          end
          ref_onehot = ($countones(in_bits) == 1);
        end
      end
    end else if (out_ready) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
    end
  endtask

  task automatic model_check();
    logic       ev;
    logic [1:0] lc, mc;
    ev = (q_lsb.size() != 0);
    lc = ev ? 2'(q_lsb[0]) : 2'b00;
    mc = ev ? 2'(q_msb[0]) : 2'b00;
    chk("lsb in_ready",   {3'b0, l_in_ready},   {3'b0, !ev});
    chk("lsb out_valid",  {3'b0, l_out_valid},  {3'b0, ev});
    chk("lsb out_code",   {2'b0, l_out_code},   {2'b0, lc});
    chk("lsb out_last",   {3'b0, l_out_last},   {3'b0, (q_lsb.size() == 1)});
    chk("lsb onehot",     {3'b0, l_onehot},     {3'b0, ref_onehot});
    chk("lsb zero_pulse", {3'b0, l_zero_pulse}, {3'b0, ref_zero});
    chk("msb in_ready",   {3'b0, m_in_ready},   {3'b0, !ev});
    chk("msb out_valid",  {3'b0, m_out_valid},  {3'b0, ev});
    chk("msb out_code",   {2'b0, m_out_code},   {2'b0, mc});
    chk("msb out_last",   {3'b0, m_out_last},   {3'b0, (q_msb.size() == 1)});
    chk("msb onehot",     {3'b0, m_onehot},     {3'b0, ref_onehot});
    chk("msb zero_pulse", {3'b0, m_zero_pulse}, {3'b0, ref_zero});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic send_and_drain(input logic [3:0] bits);
    in_valid  = 1'b1;
    in_bits   = bits;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    vecs[0] = '{4'b0001, 1, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{4'b0010, 1, 8'h01, 8'h01, 1'b1};
    vecs[2] = '{4'b0100, 1, 8'h02, 8'h02, 1'b1};
    vecs[3] = '{4'b1000, 1, 8'h03, 8'h03, 1'b1};
    vecs[4] = '{4'b1011, 3, 8'b00_11_01_00, 8'b00_00_01_11, 1'b0};
    vecs[5] = '{4'b0110, 2, 8'b00_00_10_01, 8'b00_00_01_10, 1'b0};
    vecs[6] = '{4'b1111, 4, 8'b11_10_01_00, 8'b00_01_10_11, 1'b0};

    in_valid  = 1'b0;
    in_bits   = 4'd0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2 model_check();
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table vectors: one word at a time, consumer always ready.
    for (int i = 0; i < 7; i++) begin
      in_valid  = 1'b1;
      in_bits   = vecs[i].bits;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int j = 0; j < vecs[i].n; j++) begin
        chk("tbl lsb code", {2'b0, l_out_code}, {2'b0, vecs[i].lsb_seq[2*j +: 2]});
        chk("tbl msb code", {2'b0, m_out_code}, {2'b0, vecs[i].msb_seq[2*j +: 2]});
        chk("tbl valid",    {3'b0, l_out_valid}, 4'd1);
        chk("tbl last",     {3'b0, l_out_last}, {3'b0, (j == vecs[i].n - 1)});
        chk("tbl onehot",   {3'b0, l_onehot},   {3'b0, vecs[i].onehot});
        chk("tbl in_ready", {3'b0, l_in_ready}, 4'd0);
        step();
      end
      chk("tbl bubble in_ready", {3'b0, l_in_ready}, 4'd1);
      chk("tbl bubble valid",    {3'b0, l_out_valid}, 4'd0);
    end

    // Backpressure: 0110 held for three cycles of out_ready = 0.
    in_valid  = 1'b1;
    in_bits   = 4'b0110;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp code held", {2'b0, l_out_code}, 4'd1);
      chk("bp valid held", {3'b0, l_out_valid}, 4'd1);
      chk("bp in_ready", {3'b0, l_in_ready}, 4'd0);
      step();
    end
    out_ready = 1'b1;
    chk("bp code 4th", {2'b0, l_out_code}, 4'd1);
    step();
    chk("bp code second", {2'b0, l_out_code}, 4'd2);
    chk("bp last second", {3'b0, l_out_last}, 4'd1);
    step();
    chk("bp idle", {3'b0, l_in_ready}, 4'd1);

    // Zero words back-to-back after a one-hot word.
    send_and_drain(4'b0010);
    in_valid = 1'b1;
    in_bits  = 4'b0000;
    step();
    chk("zero pulse 1", {3'b0, l_zero_pulse}, 4'd1);
    chk("zero in_ready 1", {3'b0, l_in_ready}, 4'd1);
    step();
    chk("zero pulse 2", {3'b0, l_zero_pulse}, 4'd1);
    chk("zero onehot held", {3'b0, l_onehot}, 4'd1);
    chk("zero no valid", {3'b0, l_out_valid}, 4'd0);
    in_valid = 1'b0;
    step();
    chk("zero pulse end", {3'b0, l_zero_pulse}, 4'd0);

    // Reset after two of four codes of 1111.
    in_valid  = 1'b1;
    in_bits   = 4'b1111;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("pre-reset code", {2'b0, l_out_code}, 4'd2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst valid", {3'b0, l_out_valid}, 4'd0);
    chk("rst code",  {2'b0, m_out_code}, 4'd0);
    model_check();
    step();
    rst_n = 1'b1;
    chk("rst release in_ready", {3'b0, l_in_ready}, 4'd1);
    repeat (3) step();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_bits   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/enc4to2_stream.md
# enc4to2_stream

Streaming 4-to-2 encoder: the inverse of the team's 2-to-4 decoder. It accepts a 4-bit request word (i0..i3) on a valid/ready handshake and emits the 2-bit binary code (y0 = MSB, y1 = LSB) of every set bit, one code per output handshake, in a fixed scan order. It sits between request-generating logic and any consumer of the decoder's select encoding. Zero words and multi-hot words are handled explicitly, not treated as errors.

## Interface
- LSB_FIRST, default 1: scan order. 1 emits i0 to i3; 0 emits i3 to i0.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request word present.
- in_bits  input  4  request word; bit k is i_k.
- in_ready  output  1  block can accept a word.
- out_valid  output  1  out_code is valid.
- out_code  output  2  encoded index; out_code[1] = y0, out_code[0] = y1.
- out_last  output  1  current code is the last one for this word.
- out_ready  input  1  consumer accepts out_code.
- onehot  output  1  last accepted nonzero word had exactly one bit set.
- zero_pulse  output  1  one-cycle pulse: an all-zero word was accepted.

## Operation
- States are IDLE and EMIT. The block holds a 4-bit pending register.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - Accept on in_valid && in_ready.
  - Accepted word == 0: pending unchanged, zero_pulse = 1 for the next cycle only, stay in IDLE, onehot unchanged.
  - Accepted word != 0: pending <= in_bits, onehot <= (popcount == 1), go to EMIT.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - out_code = index of the lowest set pending bit (LSB_FIRST = 1) or the highest (LSB_FIRST = 0).
  - out_last = 1 when exactly one pending bit remains.
  - On out_valid && out_ready, the selected bit is cleared. If out_last, go to IDLE; else stay in EMIT with the next code.
  - out_ready = 0 holds out_code and out_last stable. Pending is not altered.
- Code mapping matches the decoder: i0 -> 00, i1 -> 01, i2 -> 10, i3 -> 11, written as y0 y1.
- in_bits and in_valid are ignored while in EMIT. No word is lost, because in_ready = 0.
- out_code, out_last and onehot are driven from registers and pending only. There is no combinational path from in_* to out_*.

## Timing
- Reset (rst_n low, at any time, including mid-EMIT):
  - state = IDLE, pending = 0, out_valid = 0, out_code = 00, out_last = 0, onehot = 0, zero_pulse = 0.
  - in_ready = 1 as soon as reset is released (it is combinational from state).
  - A word partially emitted when reset hits is discarded.
- Latency: word accepted at edge N gives out_valid = 1 in the cycle after edge N, carrying the first code.
- Throughput: with out_ready held at 1, one code per cycle. A word with k set bits occupies EMIT for k cycles.
- After the final handshake at edge M, the block is in IDLE with in_ready = 1 in the cycle after edge M. This gives one bubble cycle between words. A new word can be accepted at edge M+1 at the earliest.
- zero_pulse is high for exactly the one cycle after the accepting edge. Back-to-back zero words give a pulse on every cycle.
- onehot is updated only when a nonzero word is accepted, and is held until the next one.

## Test plan
- Reset mid-operation:
  - Stimulus: accept 4'b1111; after two handshakes, assert rst_n = 0.
  - Required: all outputs return to reset values immediately, in_ready = 1 after release, no further codes.
- One-hot sweep (LSB_FIRST = 1, out_ready = 1):
  - Stimulus: send 0001, 0010, 0100, 1000.
  - Required: out_code = 00, 01, 10, 11 in turn, each with out_last = 1 and onehot = 1, one bubble between words.
- Multi-hot, both scan orders:
  - Stimulus: send 4'b1011 with LSB_FIRST = 1.
  - Required: codes 00, 01, 11 with out_last on 11; onehot = 0.
  - Stimulus: same word with LSB_FIRST = 0.
  - Required: codes 11, 01, 00 with out_last on 00.
- Backpressure:
  - Stimulus: send 4'b0110, hold out_ready = 0 for 3 cycles, then set it to 1.
  - Required: out_code = 01 stable with out_valid = 1 for 4 cycles, then 10 with out_last = 1; in_ready = 0 throughout EMIT.
- Zero word:
  - Stimulus: send 4'b0000 twice back-to-back.
  - Required: zero_pulse high on two consecutive cycles, out_valid never asserted, onehot unchanged, in_ready stays 1.
